id_decode_stage: RTL and testbench

Parametrised instruction-decode pipeline stage: a NUM_REGS-entry register file with one write port and two read ports, plus field extraction, immediate extension and a registered ID/EX output bank with valid/stall/flush control. It sits between instruction fetch and execute. It replaces the unparametrised decode stage by adding generic data width and register count, pipeline handshake and reset.

---
 rtl/id_decode_stage.sv | 117 +++++++++++
 tb/tb_id_decode_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// ID stage: register file, field extraction, immediate extension and a registered ID/EX bank.
// Optional write-through forwarding into the captured operands when ID_BYPASS_EN is defined.
module id_decode_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              register_write,
  input  logic [4:0]        write_addr,
  input  logic [DATA_W-1:0] write_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        rd_addr,
  output logic [DATA_W-1:0] extended_imm,
  output logic [4:0]        shamt,
  output logic [5:0]        opcode,
  output logic [5:0]        funct
);

  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  // Register 0 and addresses beyond the implemented range are never stored or read.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < REG_LIMIT);
  endfunction

  logic [DATA_W-1:0] regs_r [32];
  logic              wr_en_s;
  logic [4:0]        rs_sel_s;
  logic [4:0]        rt_sel_s;
  logic              rs_hit_s;
  logic              rt_hit_s;
  logic [DATA_W-1:0] rs_rd_s;
  logic [DATA_W-1:0] rt_rd_s;
  logic [DATA_W-1:0] imm_s;

  always_comb begin
    wr_en_s = register_write && addr_ok(write_addr);
  end

  // Register file storage, written from writeback independent of stall/flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= '0;
    end else if (wr_en_s) begin
      regs_r[write_addr] <= write_result;
    end
  end

  // During a stall the held addresses re-read the file so late writebacks are picked up.
  always_comb begin
    rs_sel_s = stall ? rs_addr : instruction[25:21];
    rt_sel_s = stall ? rt_addr : instruction[20:16];
`ifdef ID_BYPASS_EN
    rs_hit_s = wr_en_s && (write_addr == rs_sel_s);
    rt_hit_s = wr_en_s && (write_addr == rt_sel_s);
`else
    rs_hit_s = 1'b0;
    rt_hit_s = 1'b0;
`endif
    if (!addr_ok(rs_sel_s))  rs_rd_s = '0;
    else if (rs_hit_s)       rs_rd_s = write_result;
    else                     rs_rd_s = regs_r[rs_sel_s];
    if (!addr_ok(rt_sel_s))  rt_rd_s = '0;
    else if (rt_hit_s)       rt_rd_s = write_result;
    else                     rt_rd_s = regs_r[rt_sel_s];
  end

  // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
  always_comb begin
    case (instruction[31:26])
      6'h0C, 6'h0D, 6'h0E: imm_s = DATA_W'(instruction[15:0]);
      default:             imm_s = DATA_W'($signed(instruction[15:0]));
    endcase
  end

  // ID/EX bank: flush beats stall, stall holds fields but refreshes operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      rs           <= '0;
      rt           <= '0;
      rs_addr      <= 5'd0;
      rt_addr      <= 5'd0;
      rd_addr      <= 5'd0;
      extended_imm <= '0;
      shamt        <= 5'd0;
      opcode       <= 6'd0;
      funct        <= 6'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall) begin
      rs <= rs_rd_s;
      rt <= rt_rd_s;
    end else begin
      out_valid    <= in_valid;
      rs           <= rs_rd_s;
      rt           <= rt_rd_s;
      rs_addr      <= instruction[25:21];
      rt_addr      <= instruction[20:16];
      rd_addr      <= instruction[15:11];
      extended_imm <= imm_s;
      shamt        <= instruction[10:6];
      opcode       <= instruction[31:26];
      funct        <= instruction[5:0];
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: a 32x32 instance plus a 16-bit/16-register instance.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        register_write = 1'b0;
  logic [4:0]  write_addr = 5'd0;
  logic [31:0] write_result = 32'd0;

  logic        out_valid;
  logic [31:0] rs, rt, extended_imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic [5:0]  opcode, funct;

  logic        s_out_valid;
  logic [15:0] s_rs, s_rt, s_extended_imm;
  logic [4:0]  s_rs_addr, s_rt_addr, s_rd_addr, s_shamt;
  logic [5:0]  s_opcode, s_funct;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
    .stall(stall), .flush(flush), .register_write(register_write),
    .write_addr(write_addr), .write_result(write_result),
    .out_valid(out_valid), .rs(rs), .rt(rt), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .extended_imm(extended_imm), .shamt(shamt),
    .opcode(opcode), .funct(funct)
  );

  id_decode_stage #(.DATA_W(16), .NUM_REGS(16)) dut_small (
    .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
    .stall(stall), .flush(flush), .register_write(register_write),
    .write_addr(write_addr), .write_result(write_result[15:0]),
    .out_valid(s_out_valid), .rs(s_rs), .rt(s_rt), .rs_addr(s_rs_addr), .rt_addr(s_rt_addr),
    .rd_addr(s_rd_addr), .extended_imm(s_extended_imm), .shamt(s_shamt),
    .opcode(s_opcode), .funct(s_funct)
  );

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic [5:0]  op;
    logic [4:0]  rsa;
    logic [4:0]  rta;
    logic [4:0]  rda;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] imm32;
    logic [15:0] imm16;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h34018001, 1'b1, 6'h0D, 5'd0, 5'd1, 5'd16, 5'd0,  6'h01, 32'h00008001, 16'h8001};
    vecs[1] = '{32'h20028001, 1'b1, 6'h08, 5'd0, 5'd2, 5'd16, 5'd0,  6'h01, 32'hFFFF8001, 16'h8001};
    vecs[2] = '{32'h3043FFFF, 1'b1, 6'h0C, 5'd2, 5'd3, 5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 16'hFFFF};
    vecs[3] = '{32'h38A57FFF, 1'b1, 6'h0E, 5'd5, 5'd5, 5'd15, 5'd31, 6'h3F, 32'h00007FFF, 16'h7FFF};
    vecs[4] = '{32'h00221820, 1'b0, 6'h00, 5'd1, 5'd2, 5'd3,  5'd0,  6'h20, 32'h00001820, 16'h1820};
    vecs[5] = '{32'h2C009000, 1'b1, 6'h0B, 5'd0, 5'd0, 5'd18, 5'd0,  6'h00, 32'hFFFF9000, 16'h9000};
    vecs[6] = '{32'h3C018000, 1'b1, 6'h0F, 5'd0, 5'd1, 5'd16, 5'd0,  6'h00, 32'hFFFF8000, 16'h8000};

    // Reset held across edges with a live instruction on the inputs.
    instruction = 32'h34018001;
    in_valid    = 1'b1;
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_imm", extended_imm, 32'd0);
    chk("rst_rtaddr", {27'd0, rt_addr}, 32'd0);
    reset = 1'b0;

    // Field decode and immediate extension table.
    for (int i = 0; i < 7; i++) begin
      instruction = vecs[i].instr;
      in_valid    = vecs[i].vld;
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].vld});
      chk($sformatf("v%0d_op", i), {26'd0, opcode}, {26'd0, vecs[i].op});
      chk($sformatf("v%0d_rsa", i), {27'd0, rs_addr}, {27'd0, vecs[i].rsa});
      chk($sformatf("v%0d_rta", i), {27'd0, rt_addr}, {27'd0, vecs[i].rta});
      chk($sformatf("v%0d_rda", i), {27'd0, rd_addr}, {27'd0, vecs[i].rda});
      chk($sformatf("v%0d_sh", i), {27'd0, shamt}, {27'd0, vecs[i].sh});
      chk($sformatf("v%0d_fn", i), {26'd0, funct}, {26'd0, vecs[i].fn});
      chk($sformatf("v%0d_imm", i), extended_imm, vecs[i].imm32);
      chk($sformatf("v%0d_imm16", i), {16'd0, s_extended_imm}, {16'd0, vecs[i].imm16});
      chk($sformatf("v%0d_rs", i), rs, 32'd0);
    end

    // Same-edge write of $3 with a read of $3.
    instruction    = 32'h00600000;
    in_valid       = 1'b1;
    register_write = 1'b1;
    write_addr     = 5'd3;
    write_result   = 32'hDEADBEEF;
    tick();
`ifdef ID_BYPASS_EN
    chk("byp_rs_same", rs, 32'hDEADBEEF);
    chk("byp_rs_same16", {16'd0, s_rs}, 32'h0000BEEF);
`else
    chk("byp_rs_same", rs, 32'd0);
    chk("byp_rs_same16", {16'd0, s_rs}, 32'd0);
`endif
    register_write = 1'b0;
    tick();
    chk("byp_rs_next", rs, 32'hDEADBEEF);
    chk("byp_rs_next16", {16'd0, s_rs}, 32'h0000BEEF);

    // Writes to $0 are dropped, including a same-edge read.
    instruction    = 32'h00000000;
    register_write = 1'b1;
    write_addr     = 5'd0;
    write_result   = 32'h00001234;
    tick();
    chk("r0_same", rs, 32'd0);
    register_write = 1'b0;
    tick();
    chk("r0_next", rs, 32'd0);

    // $20 exists in the 32-register build only.
    register_write = 1'b1;
    write_addr     = 5'd20;
    write_result   = 32'd5;
    tick();
    register_write = 1'b0;
    instruction    = 32'h02800000;
    tick();
    chk("r20_rs32", rs, 32'd5);
    chk("r20_rs16", {16'd0, s_rs}, 32'd0);

    // Stall: fields hold while the operand is re-read through the held rs_addr.
    instruction = 32'h34A01234;
    in_valid    = 1'b1;
    tick();
    chk("st_load_rs", rs, 32'd0);
    stall       = 1'b1;
    instruction = 32'hFFFFFFFF;
    in_valid    = 1'b0;
    tick();
    chk("st1_op", {26'd0, opcode}, 32'h0000000D);
    chk("st1_valid", {31'd0, out_valid}, 32'd1);
    register_write = 1'b1;
    write_addr     = 5'd5;
    write_result   = 32'h00000055;
    tick();
`ifdef ID_BYPASS_EN
    chk("st2_rs", rs, 32'h00000055);
`else
    chk("st2_rs", rs, 32'd0);
`endif
    chk("st2_imm", extended_imm, 32'h00001234);
    register_write = 1'b0;
    tick();
    chk("st3_rs", rs, 32'h00000055);
    chk("st3_valid", {31'd0, out_valid}, 32'd1);
    chk("st3_rsaddr", {27'd0, rs_addr}, 32'd5);
    flush = 1'b1;
    tick();
    chk("stfl_valid", {31'd0, out_valid}, 32'd0);
    chk("stfl_op", {26'd0, opcode}, 32'h0000000D);
    stall = 1'b0;
    flush = 1'b0;

    // Asynchronous reset mid-cycle wipes outputs and the register file.
    register_write = 1'b1;
    write_addr     = 5'd7;
    write_result   = 32'd9;
    tick();
    register_write = 1'b0;
    instruction    = 32'h00E00000;
    in_valid       = 1'b1;
    tick();
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_pre_rs", rs, 32'd9);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_rs", rs, 32'd0);
    chk("ar_rsaddr", {27'd0, rs_addr}, 32'd0);
    #1 reset = 1'b0;
    tick();
    chk("ar_post_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_post_rs", rs, 32'd0);
    chk("ar_post_rsaddr", {27'd0, rs_addr}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
